// File: rtl/counter_b4_pkg.sv
// Shared definitions for the 4-bit counter driver: op encodings, FSM states
// and the counter data width.
package counter_b4_pkg;

   localparam int CNT_W = 4;

   localparam logic [1:0] MODE_UP1  = 2'b00;
   localparam logic [1:0] MODE_DN1  = 2'b01;
   localparam logic [1:0] MODE_UP3  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_DRAIN = 3'd2,
      ST_CHECK = 3'd3,
      ST_RESP  = 3'd4
   } drv_state_e;

endpackage

// File: rtl/counter_b4_model.sv
// Shadow model of the 4-bit counter: final value expected after a command,
// computed with modulo-16 arithmetic on the low nibble of the tick count.
module counter_b4_model
   import counter_b4_pkg::*;
(
   input  logic [1:0]       i_op,
   input  logic [CNT_W-1:0] i_q0,
   input  logic [CNT_W-1:0] i_len,
   input  logic [CNT_W-1:0] i_data,
   output logic [CNT_W-1:0] o_expected
);

   logic [CNT_W-1:0] w_len3;

   // 3*len mod 16 as (2*len + len) on 4 bits
   assign w_len3 = {i_len[CNT_W-2:0], 1'b0} + i_len;

   always_comb begin
      o_expected = i_data;
      unique case (i_op)
         MODE_UP1:  o_expected = i_q0 + i_len;
         MODE_DN1:  o_expected = i_q0 - i_len;
         MODE_UP3:  o_expected = i_q0 + w_len3;
         MODE_LOAD: o_expected = i_data;
         default:   o_expected = i_data;
      endcase
   end

endmodule

// File: rtl/counter_b4_driver.sv
// Command-driven sequencer for an external 4-bit counter: issues enabled
// ticks, counts ripple-carries, and checks the final value against a shadow model.
module counter_b4_driver
   import counter_b4_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input  logic             drv_clk,
   input  logic             drv_reset,
   // cmd: accepted on cmd_valid & cmd_ready; rsp: held stable until rsp_valid & rsp_ready
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [3:0]       cmd_data,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             b4_enable,
   output logic [1:0]       b4_mode,
   output logic [3:0]       b4_D,
   input  logic [3:0]       b4_Q,
   input  logic             b4_rco,
   input  logic             b4_load,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [3:0]       rsp_q,
   output logic [LEN_W-1:0] rsp_wraps,
   output logic             rsp_err,
   output logic [2:0]       dbg_state
);

   drv_state_e       r_state;
   drv_state_e       w_next;
   logic [1:0]       r_op;
   logic [3:0]       r_data;
   logic [3:0]       r_len4;
   logic [3:0]       r_q0;
   logic [LEN_W-1:0] r_cnt;
   logic             r_first;
   logic [LEN_W-1:0] r_wraps;
   logic             r_load_seen;
   logic [3:0]       r_rsp_q;
   logic             r_rsp_err;
   logic             w_accept;
   logic [3:0]       w_expected;

   assign w_accept = (r_state == ST_IDLE) && cmd_valid;

   counter_b4_model u_model (
      .i_op       (r_op),
      .i_q0       (r_q0),
      .i_len      (r_len4),
      .i_data     (r_data),
      .o_expected (w_expected)
   );

   always_ff @(posedge drv_clk) begin
      if (drv_reset) r_state <= ST_IDLE;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd_op != MODE_LOAD && cmd_len == '0) w_next = ST_CHECK;
               else                                      w_next = ST_ISSUE;
            end
         end
         ST_ISSUE: if (r_cnt == LEN_W'(1)) w_next = ST_DRAIN;
         ST_DRAIN: w_next = ST_CHECK;
         ST_CHECK: w_next = ST_RESP;
         ST_RESP:  if (rsp_ready) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (r_state == ST_IDLE);
      b4_enable = (r_state == ST_ISSUE);
      rsp_valid = (r_state == ST_RESP);
   end

   assign b4_mode   = r_op;
   assign b4_D      = r_data;
   assign rsp_q     = r_rsp_q;
   assign rsp_wraps = r_wraps;
   assign rsp_err   = r_rsp_err;
   assign dbg_state = r_state;

   // The first ISSUE cycle is not sampled: rco is registered, so it lags each tick by one cycle.
   always_ff @(posedge drv_clk) begin
      if (drv_reset) begin
         r_op        <= MODE_UP1;
         r_data      <= '0;
         r_len4      <= '0;
         r_q0        <= '0;
         r_cnt       <= '0;
         r_first     <= 1'b0;
         r_wraps     <= '0;
         r_load_seen <= 1'b0;
         r_rsp_q     <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op        <= cmd_op;
                  r_data      <= cmd_data;
                  r_len4      <= cmd_len[3:0];
                  r_q0        <= b4_Q;
                  r_cnt       <= (cmd_op == MODE_LOAD) ? LEN_W'(1) : cmd_len;
                  r_first     <= 1'b1;
                  r_wraps     <= '0;
                  r_load_seen <= 1'b0;
               end
            end
            ST_ISSUE: begin
               r_cnt   <= r_cnt - LEN_W'(1);
               r_first <= 1'b0;
               if (!r_first && b4_rco && r_wraps != '1) r_wraps <= r_wraps + LEN_W'(1);
            end
            ST_DRAIN: begin
               r_load_seen <= b4_load;
               if (b4_rco && r_wraps != '1) r_wraps <= r_wraps + LEN_W'(1);
            end
            ST_CHECK: begin
               r_rsp_q   <= b4_Q;
               r_rsp_err <= (b4_Q != w_expected) || (r_op == MODE_LOAD && !r_load_seen);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_b4_driver.sv
// Bench for counter_b4_driver: behavioural 4-bit counter as the environment,
// directed vector table, hand sequences for reset/backpressure, random commands.
module tb_counter_b4_driver;

   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             drv_reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [3:0]       cmd_data;
   logic [LEN_W-1:0] cmd_len;
   logic             b4_enable;
   logic [1:0]       b4_mode;
   logic [3:0]       b4_D;
   logic [3:0]       b4_Q;
   logic             b4_rco;
   logic             b4_load;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [3:0]       rsp_q;
   logic [LEN_W-1:0] rsp_wraps;
   logic             rsp_err;
   logic [2:0]       dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [12:0] exp_q[$];   // {q[3:0], err, wraps[7:0]}

   always #5 clk = ~clk;

   counter_b4_driver #(.LEN_W(LEN_W)) dut (
      .drv_clk   (clk),
      .drv_reset (drv_reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_len   (cmd_len),
      .b4_enable (b4_enable),
      .b4_mode   (b4_mode),
      .b4_D      (b4_D),
      .b4_Q      (b4_Q),
      .b4_rco    (b4_rco),
      .b4_load   (b4_load),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_q     (rsp_q),
      .rsp_wraps (rsp_wraps),
      .rsp_err   (rsp_err),
      .dbg_state (dbg_state)
   );

   // Environment: registered 4-bit up/down/load counter with rco and load flags
   logic [3:0] cnt_q    = 4'd0;
   logic       cnt_rco  = 1'b0;
   logic       cnt_load = 1'b0;
   logic       preset_en  = 1'b0;
   logic [3:0] preset_val = 4'd0;
   logic       force_en   = 1'b0;
   logic [3:0] force_val  = 4'd0;

   always @(posedge clk) begin
      if (preset_en) begin
         cnt_q    <= preset_val;
         cnt_rco  <= 1'b0;
         cnt_load <= 1'b0;
      end else if (b4_enable) begin
         case (b4_mode)
            2'b00: begin cnt_q <= cnt_q + 4'd1; cnt_rco <= (cnt_q == 4'hF); end
            2'b01: begin cnt_q <= cnt_q - 4'd1; cnt_rco <= (cnt_q == 4'h0); end
            2'b10: begin cnt_q <= cnt_q + 4'd3; cnt_rco <= (cnt_q >= 4'hD); end
            default: begin cnt_q <= b4_D; cnt_rco <= 1'b0; end
         endcase
         cnt_load <= (b4_mode == 2'b11);
      end else begin
         cnt_rco  <= 1'b0;
         cnt_load <= 1'b0;
      end
   end

   assign b4_Q    = force_en ? force_val : cnt_q;
   assign b4_rco  = cnt_rco;
   assign b4_load = cnt_load;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: final value and wrap count from whole-number arithmetic on the full tick count
   function automatic logic [12:0] ref_resp(input logic [1:0] op, input logic [3:0] data,
                                            input logic [7:0] len, input logic [3:0] q0);
      int s, q, w;
      case (op)
         2'b00: begin s = int'(q0) + int'(len);     q = s % 16; w = s / 16; end
         2'b01: begin s = int'(q0) - int'(len);     q = ((s % 16) + 16) % 16;
                      w = (int'(len) + 15 - int'(q0)) / 16; end
         2'b10: begin s = int'(q0) + 3 * int'(len); q = s % 16; w = s / 16; end
         default: begin q = int'(data); w = 0; end
      endcase
      if (w > 255) w = 255;
      return {q[3:0], 1'b0, w[7:0]};
   endfunction

   task automatic preset(input logic [3:0] q);
      @(negedge clk);
      preset_en  = 1'b1;
      preset_val = q;
      @(negedge clk);
      preset_en  = 1'b0;
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [7:0] len,
                          input logic fault, input logic [3:0] fq, input int hold, input string tag);
      int cyc, n_en, exp_lat, exp_en;
      logic bad;
      logic [12:0] e;
      exp_lat = (op == 2'b11) ? 4 : ((len == 8'd0) ? 2 : int'(len) + 3);
      exp_en  = (op == 2'b11) ? 1 : int'(len);
      @(negedge clk);
      chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_len   = len;
      @(negedge clk);
      cmd_valid = 1'b0;
      if (fault) begin force_en = 1'b1; force_val = fq; end
      cyc = 1; n_en = 0; bad = 1'b0;
      while (!rsp_valid && cyc < 400) begin
         if (b4_enable) begin
            n_en++;
            if (b4_mode !== op || b4_D !== data) bad = 1'b1;
         end
         if (cmd_ready !== 1'b0) bad = 1'b1;
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      chk({tag, "_enables"}, 32'(n_en), 32'(exp_en));
      chk({tag, "_issue_sig"}, 32'(bad), 32'd0);
      e = exp_q.pop_front();
      chk({tag, "_rsp_q"}, 32'(rsp_q), 32'(e[12:9]));
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(e[8]));
      chk({tag, "_rsp_wraps"}, 32'(rsp_wraps), 32'(e[7:0]));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
         chk({tag, "_hold_ready"}, 32'(cmd_ready), 32'd0);
         chk({tag, "_hold_rsp"}, {19'd0, rsp_q, rsp_err, rsp_wraps}, {19'd0, e});
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      force_en  = 1'b0;
      chk({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
   endtask

   typedef struct {
      logic [1:0] op;
      logic [3:0] data;
      logic [7:0] len;
      logic [3:0] q_init;
      logic       fault;
      logic [3:0] fault_q;
      logic [3:0] e_q;
      logic       e_err;
      logic [7:0] e_w;
      int         hold;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{2'b11, 4'hA, 8'd0,   4'h3, 1'b0, 4'h0, 4'hA, 1'b0, 8'd0, 0};
      vecs[1] = '{2'b00, 4'h0, 8'd5,   4'hE, 1'b0, 4'h0, 4'h3, 1'b0, 8'd1, 0};
      vecs[2] = '{2'b01, 4'h0, 8'd3,   4'h1, 1'b0, 4'h0, 4'hE, 1'b0, 8'd1, 5};
      vecs[3] = '{2'b10, 4'h0, 8'd4,   4'h0, 1'b1, 4'hB, 4'hB, 1'b1, 8'd0, 0};
      vecs[4] = '{2'b00, 4'h5, 8'd0,   4'h7, 1'b0, 4'h0, 4'h7, 1'b0, 8'd0, 0};
      vecs[5] = '{2'b01, 4'h0, 8'd20,  4'h5, 1'b0, 4'h0, 4'h1, 1'b0, 8'd1, 0};
      vecs[6] = '{2'b10, 4'h0, 8'd16,  4'h9, 1'b0, 4'h0, 4'h9, 1'b0, 8'd3, 0};
      vecs[7] = '{2'b11, 4'h0, 8'd200, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 8'd0, 0};

      drv_reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = 4'h0;
      cmd_len   = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      drv_reset = 1'b0;
      chk("rst_state", 32'(dbg_state), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_outs", {22'd0, b4_enable, b4_mode, b4_D, rsp_valid, rsp_err},  32'd0);
      chk("rst_rsp", {20'd0, rsp_q, rsp_wraps}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         preset(vecs[i].q_init);
         exp_q.push_back({vecs[i].e_q, vecs[i].e_err, vecs[i].e_w});
         run_cmd(vecs[i].op, vecs[i].data, vecs[i].len, vecs[i].fault, vecs[i].fault_q,
                 vecs[i].hold, $sformatf("vec%0d", i));
      end

      // Reset in the third ISSUE cycle of a 10-tick command
      preset(4'h0);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_len = 8'd10; cmd_data = 4'h6;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_enable_before", 32'(b4_enable), 32'd1);
      drv_reset = 1'b1;
      @(negedge clk);
      drv_reset = 1'b0;
      chk("midrst_enable", 32'(b4_enable), 32'd0);
      chk("midrst_ready", 32'(cmd_ready), 32'd1);
      chk("midrst_outs", {25'd0, b4_mode, b4_D, rsp_valid}, 32'd0);
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid || b4_enable) seen++;
         end
         chk("midrst_no_rsp", 32'(seen), 32'd0);
      end

      // Random commands against the arithmetic reference
      for (int i = 0; i < 25; i++) begin
         logic [1:0] op;
         logic [3:0] data, q0;
         logic [7:0] len;
         op   = 2'($urandom_range(0, 3));
         data = 4'($urandom_range(0, 15));
         q0   = 4'($urandom_range(0, 15));
         len  = 8'($urandom_range(0, 40));
         preset(q0);
         exp_q.push_back(ref_resp(op, data, len, q0));
         run_cmd(op, data, len, 1'b0, 4'h0, (i % 5 == 0) ? 2 : 0, $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_b4_driver.md
COUNTER_B4_DRIVER -- requirements
Module: counter_b4_driver

Interface
REQ-001 Parameter LEN_W, default 8: width of the command tick count and the wrap counter.
REQ-002 drv_clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 drv_reset  in  1  reset; synchronous and active-high.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  driver able to accept a command.
REQ-006 cmd_op  in  2  operation code: 00 up+1, 01 down-1, 10 up+3, 11 load.
REQ-007 cmd_data  in  4  load value; used only when cmd_op=11.
REQ-008 cmd_len  in  LEN_W  number of enabled counter ticks; ignored for load.
REQ-009 b4_enable  out  1  counter enable.
REQ-010 b4_mode  out  2  counter mode; equals the latched cmd_op.
REQ-011 b4_D  out  4  counter parallel-load data.
REQ-012 b4_Q  in  4  counter registered value.
REQ-013 b4_rco  in  1  counter registered ripple-carry flag.
REQ-014 b4_load  in  1  counter registered load indication.
REQ-015 rsp_valid  out  1  response available.
REQ-016 rsp_ready  in  1  response consumed.
REQ-017 rsp_q  out  4  b4_Q sampled at check.
REQ-018 rsp_wraps  out  LEN_W  count of b4_rco-high samples; saturates at all-ones.
REQ-019 rsp_err  out  1  final value or load flag mismatched the shadow model.

Function
REQ-020 The FSM SHALL have the states IDLE, ISSUE, DRAIN, CHECK and RESP.
REQ-021 In IDLE, cmd_ready SHALL be 1; a command SHALL be accepted on a cycle with cmd_valid=1 and cmd_ready=1.
REQ-022 Acceptance SHALL latch op, data and len, capture q0=b4_Q, and clear the wrap counter.
REQ-023 Acceptance SHALL go to ISSUE, or to CHECK if op!=11 and len=0.
REQ-024 ISSUE SHALL hold b4_enable=1 and b4_mode=op; b4_D SHALL equal the latched data for every op.
REQ-025 ISSUE SHALL last len cycles, or exactly 1 cycle for load.
REQ-026 After the last ISSUE cycle the FSM SHALL go to DRAIN, lasting 1 cycle with b4_enable=0.
REQ-027 b4_rco SHALL be sampled in every ISSUE cycle except the first, and in the DRAIN cycle.
REQ-028 Each high sample SHALL increment the wrap counter, saturating at all-ones.
REQ-029 The expected value is (q0+len) mod 16 for op 00, (q0-len) mod 16 for op 01, (q0+3*len) mod 16 for op 10, and data for op 11.
REQ-030 The expected value SHALL use only len mod 16 arithmetic on 4 bits.
REQ-031 In CHECK, rsp_q SHALL be set to b4_Q.
REQ-032 In CHECK, rsp_err SHALL be set to (b4_Q != expected), OR-ed for load with (b4_load was 0 during DRAIN).
REQ-033 CHECK SHALL then go to RESP.
REQ-034 In RESP, rsp_valid SHALL be 1 with rsp_q, rsp_wraps and rsp_err stable.
REQ-035 The FSM SHALL leave RESP for IDLE on the cycle rsp_ready=1.
REQ-036 cmd_ready SHALL be 0 in every state except IDLE; there is no command queueing.
REQ-037 Latency: a count command SHALL give rsp_valid at cycle len+3 after acceptance; a load SHALL give it at cycle 4.
REQ-038 If cmd_valid is held with rsp_ready=1 in RESP, the next command SHALL be accepted no earlier than the following IDLE cycle.
REQ-039 b4_enable SHALL be 0 in IDLE, DRAIN, CHECK and RESP.

Reset
REQ-040 drv_reset=1 at a clock edge SHALL force IDLE from any state, including mid-ISSUE.
REQ-041 Reset SHALL force: b4_enable=0, b4_mode=00, b4_D=0, rsp_valid=0, rsp_q=0, rsp_wraps=0, rsp_err=0, cmd_ready=1 on the following cycle.
REQ-042 A command cut short by reset SHALL produce no response.

Structure
REQ-043 A shared package counter_b4_pkg SHALL hold: the op encodings MODE_UP1=00, MODE_DN1=01, MODE_UP3=10, MODE_LOAD=11; the FSM state enumeration; and the 4-bit width constant.
REQ-044 One sub-module, counter_b4_model, SHALL compute the expected value combinationally from (op, q0, len, data); no other hierarchy.

Verification
REQ-045 Load: op=11, data=0xA, counter at 0x3 -> one enable cycle with mode=11, D=0xA; rsp_q=0xA, rsp_err=0, rsp_wraps=0.
REQ-046 Up-count wrap: from 0xE, op=00, len=5 -> rsp_q=0x3, rsp_err=0, rsp_wraps=1.
REQ-047 Down-count wrap: from 0x1, op=01, len=3 -> rsp_q=0xE, rsp_err=0.
REQ-048 Up-by-3 with fault: from 0x0, op=10, len=4, counter forced to 0xB -> rsp_err=1, rsp_q=0xB.
REQ-049 len=0 with op=00 -> b4_enable never high; rsp_valid within 2 cycles; rsp_q equals q0.
REQ-050 Reset mid-op: reset asserted in ISSUE cycle 3 of len=10 -> b4_enable=0 next cycle, rsp_valid stays 0, cmd_ready=1.
REQ-051 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_* stable, cmd_ready=0 throughout.
